// File: rtl/ps2_scan_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 scan-code receiver slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // {extended flag, scan code}; all-zero means no key held
    typedef logic [8:0] key_code_t;

    localparam key_code_t KEY_NONE = 9'h000;

    function automatic key_code_t make_key(input logic ext, input logic [7:0] code);
        return {ext, code};
    endfunction

endpackage

// File: rtl/ps2_scan_if.sv
// ps2_scan_if: bundles the raw PS/2 pins with the decoded key code.
// Latency: n/a (wires only).
// Backpressure: none; the PS/2 pins and key code are free-running levels.
// Ports: ps2_clk/ps2_data raw pins (keyboard side drives), crt_data held key.
interface ps2_scan_if;

    logic                ps2_clk;
    logic                ps2_data;
    ps2_pkg::key_code_t  crt_data;

    // keyboard/board side drives the pins and observes the decoded key
    modport master (output ps2_clk, output ps2_data, input crt_data);
    // receiver side samples the pins and presents the decoded key
    modport slave  (input ps2_clk, input ps2_data, output crt_data);

endinterface

// File: rtl/ps2_scan_rx.sv
// ps2_rx: synchronises PS/2 pins, assembles 11-bit frames, emits one byte per frame.
// Latency: byte_vld is high 3 clk after the 11th pin falling edge.
// Backpressure: none; byte_vld is a 1-clk pulse that must be consumed immediately.
// Ports: clk, rst (async active-high), ps2_clk/ps2_data raw pins, byte_dat/byte_vld.
// Optional: PS2_SCAN_CHECK_EN enables start/stop/odd-parity frame checking.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_dat,
    output logic       byte_vld
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]        LAST_BIT = 4'(PS2_FRAME_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [1:0]        clk_sync;
    logic [2:0]        dat_sync;     // one extra stage keeps data aligned with fe
    logic              clk_prev;
    logic              fe;
    logic [3:0]        bit_cnt;
    logic [9:0]        shreg;
    logic [IDLE_W-1:0] idle_cnt;
    logic [10:0]       frame;
    logic              frame_ok;

    // frame as it stands including the bit being sampled this cycle;
    // frame[0] = start, frame[8:1] = data LSB first, frame[9] = parity, frame[10] = stop
    assign frame = {dat_sync[2], shreg};

`ifdef PS2_SCAN_CHECK_EN
    assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);
`else
    logic unused_frame_bits;
    assign unused_frame_bits = &{1'b0, frame[10], frame[9], frame[0]};
    assign frame_ok = 1'b1;
`endif

    assign byte_dat = frame[8:1];
    assign byte_vld = fe && (bit_cnt == LAST_BIT) && frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 3'b111;
            clk_prev <= 1'b1;
            fe       <= 1'b0;
            bit_cnt  <= 4'd0;
            shreg    <= '0;
            idle_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
            clk_prev <= clk_sync[1];
            fe       <= clk_prev && !clk_sync[1];

            if (fe) begin
                idle_cnt <= '0;
                shreg    <= frame[10:1];
                bit_cnt  <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
            end else if (idle_cnt >= IDLE_MAX) begin
                // idle counter saturates; a stalled partial frame is dropped
                bit_cnt <= 4'd0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scan.sv
// ps2_scan: PS/2 keyboard receiver plus E0/F0 prefix decoder holding the current key.
// Latency: crt_data updates 4 clk after the 11th PS/2 clock falling edge.
// Backpressure: none; keys are level outputs, prefixes accumulate until a code byte.
// Ports: clk, rst (async active-high), ps2 (slave modport: pins in, crt_data out).
// Optional: PS2_SCAN_CHECK_EN (in ps2_rx) drops frames with bad start/stop/parity.
module ps2_scan
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    ps2_scan_if.slave   ps2
);

    logic [7:0] byte_dat;
    logic       byte_vld;
    logic       ext;
    logic       brk;
    key_code_t  crt_q;
    key_code_t  key;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2.ps2_clk),
        .ps2_data (ps2.ps2_data),
        .byte_dat (byte_dat),
        .byte_vld (byte_vld)
    );

    assign key          = make_key(ext, byte_dat);
    assign ps2.crt_data = crt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            crt_q <= KEY_NONE;
        end else if (byte_vld) begin
            if (byte_dat == PS2_EXT) begin
                ext <= 1'b1;
            end else if (byte_dat == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                // a break only releases the key actually held
                if (!brk) begin
                    crt_q <= key;
                end else if (crt_q == key) begin
                    crt_q <= KEY_NONE;
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan.sv
module tb_ps2_scan;
    import ps2_pkg::*;

    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_scan_if bus();

    ps2_scan #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .ps2 (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: crt_data got %03h expected %03h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = ~^b;
        if (bad) p = ~p;
        return {1'b1, p, b, 1'b0};
    endfunction

    // bits 0..n-1 of f, 30 ns high and low phases, pin edges kept off clk edges
    task automatic send_bits(input logic [10:0] f, input int n);
        @(negedge clk);
        #2;
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            #15;
            bus.ps2_clk = 1'b0;
            #30;
            bus.ps2_clk = 1'b1;
            #15;
        end
    endtask

    initial begin
        logic [10:0] f;
        logic [8:0]  cur;

        vecs[0]  = '{8'hE0, 1'b0, 9'h029};
        vecs[1]  = '{8'h75, 1'b0, 9'h175};
        vecs[2]  = '{8'hF0, 1'b0, 9'h175};
        vecs[3]  = '{8'h29, 1'b0, 9'h175};
        vecs[4]  = '{8'hE0, 1'b0, 9'h175};
        vecs[5]  = '{8'hF0, 1'b0, 9'h175};
        vecs[6]  = '{8'h75, 1'b0, 9'h000};
        vecs[7]  = '{8'h1C, 1'b0, 9'h01C};
        vecs[8]  = '{8'h1C, 1'b0, 9'h01C};
        vecs[9]  = '{8'hF0, 1'b0, 9'h01C};
        vecs[10] = '{8'hE0, 1'b0, 9'h01C};
        vecs[11] = '{8'h1C, 1'b0, 9'h01C};
        vecs[12] = '{8'hF0, 1'b0, 9'h01C};
        vecs[13] = '{8'h1C, 1'b0, 9'h000};
`ifdef PS2_SCAN_CHECK_EN
        vecs[14] = '{8'h29, 1'b1, 9'h000};
`else
        vecs[14] = '{8'h29, 1'b1, 9'h029};
`endif
        vecs[15] = '{8'h29, 1'b0, 9'h029};
        vecs[16] = '{8'hF0, 1'b1, 9'h029};
`ifdef PS2_SCAN_CHECK_EN
        vecs[17] = '{8'h66, 1'b0, 9'h066};
`else
        vecs[17] = '{8'h66, 1'b0, 9'h029};
`endif
        vecs[18] = '{8'h29, 1'b0, 9'h029};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        #23;
        check("reset_value", bus.crt_data, 9'h000);
        #27;
        rst = 1'b0;

        repeat (100) @(posedge clk);
        @(negedge clk);
        check("idle_no_change", bus.crt_data, 9'h000);

        // first frame: 0x29 with latency bound on the 11th falling edge
        f = mk_frame(8'h29, 1'b0);
        send_bits(f, 10);
        bus.ps2_data = f[10];
        #15;
        bus.ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("latency_not_early", bus.crt_data, 9'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("latency_4clk", bus.crt_data, 9'h029);
        bus.ps2_clk = 1'b1;
        #30;

        for (int i = 0; i < 19; i++) begin
            send_bits(mk_frame(vecs[i].b, vecs[i].bad_par), 11);
            @(negedge clk);
            check($sformatf("vec%0d_byte%02h", i, vecs[i].b), bus.crt_data, vecs[i].exp);
        end
        cur = vecs[18].exp;

        // partial frame followed by long idle must be discarded
        send_bits(mk_frame(8'h29, 1'b0), 5);
        repeat (TO + 100) @(posedge clk);
        @(negedge clk);
        check("timeout_no_change", bus.crt_data, cur);
        send_bits(mk_frame(8'h1C, 1'b0), 11);
        @(negedge clk);
        check("after_timeout_frame", bus.crt_data, 9'h01C);

        // asynchronous reset in the middle of a frame
        send_bits(mk_frame(8'h5A, 1'b0), 5);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_midframe", bus.crt_data, 9'h000);
        #20;
        rst = 1'b0;
        send_bits(mk_frame(8'h33, 1'b0), 11);
        @(negedge clk);
        check("frame_after_reset", bus.crt_data, 9'h033);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan.md
# ps2_scan

PS/2 keyboard scan-code receiver and decoder. Samples the raw PS/2 clock/data pins in the system clock domain, assembles 11-bit frames into bytes, interprets the E0 (extended) and F0 (break) prefixes, and presents the currently held key as a 9-bit code. Sits between the board PS/2 pins and the game input/cursor logic.

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of system clocks without a PS/2 falling edge after which a partial frame is discarded.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `crt_data` output 9: current key code.
  - bit 8 = extended flag.
  - bits 7:0 = scan code.
  - 0x000 = no key.

## Operation
- **Synchronizer:**
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - A third register on synchronized clock gives falling-edge pulse `fe` (prev=1, now=0).
- **Frame receiver:**
  - Bit counter 0..10, one increment per `fe`.
  - Shifts synchronized data on each `fe`.
  - Bit 0 = start, bits 1..8 = data LSB first, bit 9 = odd parity, bit 10 = stop.
  - On the `fe` with counter=10: byte valid pulse (1 clk), counter returns to 0.
- **Timeout:**
  - Idle counter resets on every `fe`.
  - Reaching `TIMEOUT_CYCLES` with counter≠0 clears the counter; the partial frame is dropped, no byte emitted.
- **Decoder:** flags `ext` and `brk`, both cleared by reset. On each valid byte:
  - 0xE0: set `ext`.
  - 0xF0: set `brk`.
  - Any other byte B forms code K={ext,B}:
    - If `brk`=0: `crt_data`←K.
    - If `brk`=1 and `crt_data`==K: `crt_data`←0.
    - If `brk`=1 and mismatch: `crt_data` unchanged.
    - Then clear `ext` and `brk`.
  - E0 and F0 may arrive in either order before the code byte; both flags accumulate.
  - A repeated make code (typematic) rewrites the same value.

## Timing
- Reset: `crt_data`=0x000, counters 0, flags 0, synchronizers 1 (idle-high).
- `fe` asserts 3 clk after the pin falling edge (2 sync + edge register).
- PS/2 data is sampled in the cycle `fe` is high, using the synchronized data at the same delay, so data stable across the pin edge is captured correctly.
- Byte valid pulse: same cycle as the 11th `fe`. `crt_data` updates on the next clock edge, i.e. 4 clk after the 11th pin falling edge.
- Works for PS/2 clock high/low phases ≥ 3 system clocks each.
- Reset asserted mid-frame aborts the frame immediately; the next frame starts at counter 0.
- Frames shorter than 11 edges are never emitted except via the timeout discard.

## Configuration
- `PS2_SCAN_CHECK_EN` defined:
  - A frame is accepted only if start=0, stop=1 and odd parity over data+parity holds.
  - Failing frames are silently dropped and decoder flags are left unchanged.
- Not defined: start, parity and stop bits are ignored; every 11-edge frame yields a byte.

## Structure
- Shared package `ps2_pkg`:
  - `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0.
  - `PS2_FRAME_BITS`=11.
  - 9-bit key code typedef.
- Sub-module `ps2_rx` contains synchronizer, edge detect, bit counter, shift register, timeout and optional checks. It outputs `byte[7:0]` and a valid pulse.
- Top `ps2_scan` holds the prefix decoder and `crt_data` register.

## Test plan
- Reset 50 ns, then idle → `crt_data`=0x000, no change while `ps2_clk` stays high.
- Frame 0x29 (SPACE), 30 ns phases, checks off → `crt_data`=0x029 ≤4 clk after the 11th falling edge.
- Frames E0, 75 (UP) → `crt_data`=0x175; unchanged after E0 alone.
- Then F0, 29 → `crt_data` stays 0x175 (break mismatch). Then E0, F0, 75 → `crt_data`=0x000.
- 5 falling edges then idle > `TIMEOUT_CYCLES` → no output change. Next full frame 0x1C → `crt_data`=0x01C.
- With `PS2_SCAN_CHECK_EN`: frame 0x29 with wrong parity → ignored; correct frame → 0x029. Reset asserted mid-frame → `crt_data`=0x000 asynchronously.
